// File: rtl/trap_dispatch_seq.sv
// trap_dispatch_seq
//   Consumer end of the CPIPE1 trap-decode outputs. When a trap flag arrives
//   with dec_valid, it holds the front end and squashes the instructions in
//   flight for SQUASH_CYCLES cycles. It then saves the faulting PC and the
//   cause, and hands the handler vector to the fetch/PC unit over a
//   valid/ready handshake. It also produces the one-shot conditional-skip
//   flag for the next instruction.
//
// Ports
//   clk, rst_n      clock (rising edge) and asynchronous active-low reset
//   dec_valid       trap/skip flags and pc are meaningful this cycle
//   pc              PC of the instruction currently in CPIPE1
//   GStrap, trapinstr, TAGtrap, pov_unflow
//                   trap requests (priority TAGtrap > pov_unflow > GStrap > trapinstr)
//   skipCONDenable  enable conditional skip; skip_cond is the condition result
//   vec_ready       fetch unit accepts the handler vector
//   trap_ret        handler return, clears in_trap
//   pipe_hold       stall the front end
//   pipe_squash     kill instructions in flight
//   epc, cause      saved PC and cause code of the trapping instruction
//   vec_valid       handler vector valid
//   vec_addr        handler vector address
//   skip_next       squash the next issued instruction
//   in_trap         handler active
module trap_dispatch_seq #(
  parameter int          SQUASH_CYCLES = 2,
  parameter logic [31:0] VEC_BASE      = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  input  logic [31:0] pc,
  input  logic        GStrap,
  input  logic        trapinstr,
  input  logic        TAGtrap,
  input  logic        pov_unflow,
  input  logic        skipCONDenable,
  input  logic        skip_cond,
  input  logic        vec_ready,
  input  logic        trap_ret,
  output logic        pipe_hold,
  output logic        pipe_squash,
  output logic [31:0] epc,
  output logic [2:0]  cause,
  output logic        vec_valid,
  output logic [31:0] vec_addr,
  output logic        skip_next,
  output logic        in_trap
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SQUASH = 2'd1;
  localparam logic [1:0] SAVE   = 2'd2;
  localparam logic [1:0] VECTOR = 2'd3;

  // The counter is loaded with SQUASH_CYCLES-1 so that the SQUASH state,
  // which leaves when the counter reads zero, lasts exactly SQUASH_CYCLES cycles.
  localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES - 1);

  logic [1:0] state;
  logic [3:0] sq_cnt;
  logic       req;
  logic       skip_hit;
  logic [2:0] req_cause;

  // Decode the incoming flags. Any request made while a handler is already
  // active is a double fault, and that overrides the normal priority order.
  always_comb begin
    req       = dec_valid & (TAGtrap | pov_unflow | GStrap | trapinstr);
    skip_hit  = dec_valid & skipCONDenable & skip_cond & ~req;
    req_cause = 3'd4;
    if (TAGtrap)         req_cause = 3'd1;
    else if (pov_unflow) req_cause = 3'd2;
    else if (GStrap)     req_cause = 3'd3;
    if (in_trap)         req_cause = 3'd7;
  end

  // Trap sequencer. Every output is registered, so there is no combinational
  // path from the inputs to the outputs. Requests that arrive outside IDLE
  // are dropped, because the pipe is already held and squashed. In IDLE, a
  // request beats a same-cycle trap_ret, so in_trap keeps its value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sq_cnt      <= 4'd0;
      pipe_hold   <= 1'b0;
      pipe_squash <= 1'b0;
      epc         <= 32'd0;
      cause       <= 3'd0;
      vec_valid   <= 1'b0;
      vec_addr    <= 32'd0;
      skip_next   <= 1'b0;
      in_trap     <= 1'b0;
    end else begin
      skip_next <= 1'b0;
      case (state)
        IDLE: begin
          skip_next <= skip_hit;
          if (req) begin
            epc         <= pc;
            cause       <= req_cause;
            sq_cnt      <= SQ_LOAD;
            pipe_hold   <= 1'b1;
            pipe_squash <= 1'b1;
            state       <= SQUASH;
          end else if (trap_ret) begin
            in_trap <= 1'b0;
          end
        end
        SQUASH: begin
          if (trap_ret) in_trap <= 1'b0;
          if (sq_cnt == 4'd0) begin
            pipe_squash <= 1'b0;
            state       <= SAVE;
          end else begin
            sq_cnt <= sq_cnt - 4'd1;
          end
        end
        SAVE: begin
          vec_addr  <= VEC_BASE + {25'd0, cause, 4'b0000};
          in_trap   <= 1'b1;
          vec_valid <= 1'b1;
          state     <= VECTOR;
        end
        VECTOR: begin
          if (trap_ret) in_trap <= 1'b0;
          if (vec_valid && vec_ready) begin
            vec_valid <= 1'b0;
            pipe_hold <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_dispatch_seq.sv
// tb_trap_dispatch_seq
//   Directed scenarios with hand-derived expected values, followed by a
//   randomized run checked against a cycle-timeline reference model.
module tb_trap_dispatch_seq;

  localparam int          SQ = 2;
  localparam logic [31:0] VB = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dec_valid, GStrap, trapinstr, TAGtrap, pov_unflow;
  logic        skipCONDenable, skip_cond, vec_ready, trap_ret;
  logic [31:0] pc;
  logic        pipe_hold, pipe_squash, vec_valid, skip_next, in_trap;
  logic [31:0] epc, vec_addr;
  logic [2:0]  cause;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model. It keeps the trap as an "age" in cycles since the
  // request was accepted, plus the architectural registers.
  bit          m_busy;
  int          m_age;
  logic        m_intrap, m_skip;
  logic [31:0] m_epc, m_vaddr;
  logic [2:0]  m_cause;

  trap_dispatch_seq #(.SQUASH_CYCLES(SQ), .VEC_BASE(VB)) dut (
    .clk(clk), .rst_n(rst_n), .dec_valid(dec_valid), .pc(pc),
    .GStrap(GStrap), .trapinstr(trapinstr), .TAGtrap(TAGtrap),
    .pov_unflow(pov_unflow), .skipCONDenable(skipCONDenable),
    .skip_cond(skip_cond), .vec_ready(vec_ready), .trap_ret(trap_ret),
    .pipe_hold(pipe_hold), .pipe_squash(pipe_squash), .epc(epc),
    .cause(cause), .vec_valid(vec_valid), .vec_addr(vec_addr),
    .skip_next(skip_next), .in_trap(in_trap)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_busy = 0; m_age = 0; m_intrap = 0; m_skip = 0;
    m_epc = '0; m_vaddr = '0; m_cause = '0;
  endtask

  // Advance the model by one rising edge, using the inputs present at that edge.
  task automatic model_edge();
    logic req;
    req = dec_valid & (TAGtrap | pov_unflow | GStrap | trapinstr);
    if (!m_busy) begin
      m_skip = !req && dec_valid && skipCONDenable && skip_cond;
      if (req) begin
        if (m_intrap)        m_cause = 3'd7;
        else if (TAGtrap)    m_cause = 3'd1;
        else if (pov_unflow) m_cause = 3'd2;
        else if (GStrap)     m_cause = 3'd3;
        else                 m_cause = 3'd4;
        m_epc  = pc;
        m_busy = 1;
        m_age  = 1;
      end else if (trap_ret) begin
        m_intrap = 0;
      end
    end else begin
      m_skip = 0;
      if (m_age == SQ + 1) begin
        m_intrap = 1;
        m_vaddr  = VB + 32'(m_cause) * 32'd16;
        m_age++;
      end else begin
        if (trap_ret) m_intrap = 0;
        if (m_age >= SQ + 2 && vec_ready) m_busy = 0;
        else m_age++;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic applyStimulus(input logic dv, input logic [3:0] flags,
                               input logic [31:0] p, input logic ret);
    dec_valid  = dv;
    TAGtrap    = flags[3];
    pov_unflow = flags[2];
    GStrap     = flags[1];
    trapinstr  = flags[0];
    pc         = p;
    trap_ret   = ret;
  endtask

  task automatic clear_inputs();
    applyStimulus(1'b0, 4'b0000, 32'd0, 1'b0);
    skipCONDenable = 0; skip_cond = 0; vec_ready = 0;
  endtask

  // Issue a request and advance to the first VECTOR cycle.
  task automatic drive_trap(input logic [3:0] flags, input logic [31:0] p, input logic ret);
    applyStimulus(1'b1, flags, p, ret);
    tick();
    clear_inputs();
    for (int i = 0; i < SQ + 1; i++) tick();
  endtask

  task automatic finish_vector();
    vec_ready = 1; tick(); vec_ready = 0;
  endtask

  task automatic do_ret();
    trap_ret = 1; tick(); trap_ret = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_inputs();
    model_reset();
    #12;
    n_checks++; if ({pipe_hold, pipe_squash, vec_valid, skip_next, in_trap} !== 5'b0) begin n_fail++; $display("[TB] FAIL reset_flags: got %b expected 00000", {pipe_hold, pipe_squash, vec_valid, skip_next, in_trap}); end
    n_checks++; if (epc !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_epc: got %h expected 0", epc); end
    n_checks++; if (cause !== 3'd0) begin n_fail++; $display("[TB] FAIL reset_cause: got %0d expected 0", cause); end
    n_checks++; if (vec_addr !== 32'd0) begin n_fail++; $display("[TB] FAIL reset_vec_addr: got %h expected 0", vec_addr); end
    rst_n = 1;
  endtask

  task automatic test_tag_trap();
    int sq_seen;
    sq_seen = 0;
    applyStimulus(1'b1, 4'b1000, 32'h0000_4A3C, 1'b0);
    tick();
    clear_inputs();
    n_checks++; if (pipe_hold !== 1'b1) begin n_fail++; $display("[TB] FAIL tag_hold_rise: got %b expected 1", pipe_hold); end
    for (int i = 0; i < SQ + 1; i++) begin
      if (pipe_squash === 1'b1) sq_seen++;
      tick();
    end
    n_checks++; if (sq_seen != SQ) begin n_fail++; $display("[TB] FAIL tag_squash_len: got %0d expected %0d", sq_seen, SQ); end
    n_checks++; if (vec_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL tag_vec_valid: got %b expected 1", vec_valid); end
    n_checks++; if (vec_addr !== 32'h0000_0110) begin n_fail++; $display("[TB] FAIL tag_vec_addr: got %h expected 00000110", vec_addr); end
    n_checks++; if (epc !== 32'h0000_4A3C) begin n_fail++; $display("[TB] FAIL tag_epc: got %h expected 00004a3c", epc); end
    n_checks++; if (cause !== 3'd1) begin n_fail++; $display("[TB] FAIL tag_cause: got %0d expected 1", cause); end
    n_checks++; if (in_trap !== 1'b1) begin n_fail++; $display("[TB] FAIL tag_in_trap: got %b expected 1", in_trap); end
    finish_vector();
    n_checks++; if ({vec_valid, pipe_hold} !== 2'b00) begin n_fail++; $display("[TB] FAIL tag_release: got %b expected 00", {vec_valid, pipe_hold}); end
  endtask

  task automatic test_priority();
    do_ret();
    n_checks++; if (in_trap !== 1'b0) begin n_fail++; $display("[TB] FAIL prio_ret: got %b expected 0", in_trap); end
    drive_trap(4'b1011, 32'h10, 1'b0);
    n_checks++; if (cause !== 3'd1) begin n_fail++; $display("[TB] FAIL prio_tag_cause: got %0d expected 1", cause); end
    n_checks++; if (epc !== 32'h10) begin n_fail++; $display("[TB] FAIL prio_epc: got %h expected 00000010", epc); end
    finish_vector();
    do_ret();
    drive_trap(4'b0011, 32'h10, 1'b0);
    n_checks++; if (cause !== 3'd3) begin n_fail++; $display("[TB] FAIL prio_gs_cause: got %0d expected 3", cause); end
    n_checks++; if (vec_addr !== 32'h0000_0130) begin n_fail++; $display("[TB] FAIL prio_gs_vec: got %h expected 00000130", vec_addr); end
  endtask

  // Continues from VECTOR, where the previous test left the sequencer.
  task automatic test_vector_stall();
    int stable;
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (vec_valid === 1'b1 && vec_addr === 32'h0000_0130) stable++;
    end
    n_checks++; if (stable != 5) begin n_fail++; $display("[TB] FAIL stall_stable: got %0d expected 5", stable); end
    finish_vector();
    n_checks++; if ({vec_valid, pipe_hold} !== 2'b00) begin n_fail++; $display("[TB] FAIL stall_release: got %b expected 00", {vec_valid, pipe_hold}); end
  endtask

  task automatic test_double_fault();
    n_checks++; if (in_trap !== 1'b1) begin n_fail++; $display("[TB] FAIL df_pre_in_trap: got %b expected 1", in_trap); end
    drive_trap(4'b0100, 32'h2000, 1'b0);
    n_checks++; if (cause !== 3'd7) begin n_fail++; $display("[TB] FAIL df_cause: got %0d expected 7", cause); end
    n_checks++; if (vec_addr !== 32'h0000_0170) begin n_fail++; $display("[TB] FAIL df_vec: got %h expected 00000170", vec_addr); end
    finish_vector();
    drive_trap(4'b0100, 32'h2004, 1'b1);
    n_checks++; if ({cause, in_trap} !== {3'd7, 1'b1}) begin n_fail++; $display("[TB] FAIL ret_vs_req: got %b expected 1111", {cause, in_trap}); end
    finish_vector();
    do_ret();
    n_checks++; if (in_trap !== 1'b0) begin n_fail++; $display("[TB] FAIL df_ret: got %b expected 0", in_trap); end
  endtask

  task automatic test_skip();
    applyStimulus(1'b0, 4'b1111, 32'h44, 1'b0);
    tick();
    n_checks++; if (pipe_hold !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_no_valid: got %b expected 0", pipe_hold); end
    applyStimulus(1'b1, 4'b0000, 32'h44, 1'b0);
    skipCONDenable = 1; skip_cond = 1;
    tick();
    clear_inputs();
    n_checks++; if (skip_next !== 1'b1) begin n_fail++; $display("[TB] FAIL skip_set: got %b expected 1", skip_next); end
    tick();
    n_checks++; if (skip_next !== 1'b0) begin n_fail++; $display("[TB] FAIL skip_oneshot: got %b expected 0", skip_next); end
    applyStimulus(1'b1, 4'b0001, 32'h48, 1'b0);
    skipCONDenable = 1; skip_cond = 1;
    tick();
    clear_inputs();
    n_checks++; if ({skip_next, pipe_hold} !== 2'b01) begin n_fail++; $display("[TB] FAIL skip_suppressed: got %b expected 01", {skip_next, pipe_hold}); end
    for (int i = 0; i < SQ + 1; i++) tick();
    n_checks++; if (cause !== 3'd4) begin n_fail++; $display("[TB] FAIL skip_trap_cause: got %0d expected 4", cause); end
    finish_vector();
    do_ret();
  endtask

  task automatic test_reset_mid();
    drive_trap(4'b0010, 32'h300, 1'b0);
    #2 rst_n = 0;
    #1;
    n_checks++; if ({vec_valid, pipe_hold, in_trap} !== 3'b000) begin n_fail++; $display("[TB] FAIL async_reset: got %b expected 000", {vec_valid, pipe_hold, in_trap}); end
    model_reset();
    #3 rst_n = 1;
    drive_trap(4'b0001, 32'h0000_0ABC, 1'b0);
    n_checks++; if ({cause, vec_addr} !== {3'd4, 32'h0000_0140}) begin n_fail++; $display("[TB] FAIL post_reset_seq: got %0d/%h expected 4/00000140", cause, vec_addr); end
    n_checks++; if (epc !== 32'h0000_0ABC) begin n_fail++; $display("[TB] FAIL post_reset_epc: got %h expected 00000abc", epc); end
    finish_vector();
  endtask

  task automatic test_random();
    rst_n = 0; #1; rst_n = 1;
    model_reset();
    clear_inputs();
    for (int i = 0; i < 800; i++) begin
      dec_valid      = ($urandom_range(0, 1) == 1);
      TAGtrap        = ($urandom_range(0, 7) == 0);
      pov_unflow     = ($urandom_range(0, 7) == 0);
      GStrap         = ($urandom_range(0, 7) == 0);
      trapinstr      = ($urandom_range(0, 7) == 0);
      skipCONDenable = ($urandom_range(0, 1) == 1);
      skip_cond      = ($urandom_range(0, 1) == 1);
      vec_ready      = ($urandom_range(0, 2) == 0);
      trap_ret       = ($urandom_range(0, 9) == 0);
      pc             = $urandom;
      tick();
      n_checks++; if (pipe_hold !== m_busy) begin n_fail++; $display("[TB] FAIL rnd_hold @%0d: got %b expected %b", i, pipe_hold, m_busy); end
      n_checks++; if (pipe_squash !== (m_busy && m_age <= SQ)) begin n_fail++; $display("[TB] FAIL rnd_squash @%0d: got %b expected %b", i, pipe_squash, (m_busy && m_age <= SQ)); end
      n_checks++; if (vec_valid !== (m_busy && m_age >= SQ + 2)) begin n_fail++; $display("[TB] FAIL rnd_vec_valid @%0d: got %b expected %b", i, vec_valid, (m_busy && m_age >= SQ + 2)); end
      n_checks++; if (vec_addr !== m_vaddr) begin n_fail++; $display("[TB] FAIL rnd_vec_addr @%0d: got %h expected %h", i, vec_addr, m_vaddr); end
      n_checks++; if (epc !== m_epc) begin n_fail++; $display("[TB] FAIL rnd_epc @%0d: got %h expected %h", i, epc, m_epc); end
      n_checks++; if (cause !== m_cause) begin n_fail++; $display("[TB] FAIL rnd_cause @%0d: got %0d expected %0d", i, cause, m_cause); end
      n_checks++; if (skip_next !== m_skip) begin n_fail++; $display("[TB] FAIL rnd_skip @%0d: got %b expected %b", i, skip_next, m_skip); end
      n_checks++; if (in_trap !== m_intrap) begin n_fail++; $display("[TB] FAIL rnd_in_trap @%0d: got %b expected %b", i, in_trap, m_intrap); end
    end
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_tag_trap();
    test_priority();
    test_vector_stall();
    test_double_fault();
    test_skip();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/trap_dispatch_seq.md
Name: trap_dispatch_seq

Overview:
- Consumer end of the pipeline trap-decode outputs: takes the per-instruction trap/skip flags (GStrap, trapinstr, TAGtrap, pov_unflow, skipCONDenable) plus the faulting PC.
- Runs the trap sequence: hold, squash, save EPC/cause, present the handler vector with a valid/ready handshake, then release.
- Also manages the one-shot conditional-skip flag for the next instruction.
- Sits between the CPIPE1 decode stage and the fetch/PC unit.

Parameters:
- SQUASH_CYCLES, 2, number of cycles pipe_squash is held asserted (legal 1..15).
- VEC_BASE, 32'h0000_0100, base address of the trap vector table.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  trap flags and pc are meaningful this cycle.
- pc  in  32  PC of the instruction in CPIPE1.
- GStrap  in  1  general software trap request.
- trapinstr  in  1  trap-instruction request.
- TAGtrap  in  1  tag-check trap request.
- pov_unflow  in  1  overflow/underflow trap request.
- skipCONDenable  in  1  enable conditional skip of the next instruction.
- skip_cond  in  1  condition result; sampled with skipCONDenable.
- vec_ready  in  1  fetch unit accepts the vector.
- trap_ret  in  1  handler return; clears in_trap.
- pipe_hold  out  1  stall the front end.
- pipe_squash  out  1  kill instructions in flight.
- epc  out  32  saved PC of the trapping instruction.
- cause  out  3  saved cause code.
- vec_valid  out  1  vector address valid.
- vec_addr  out  32  handler address.
- skip_next  out  1  squash the next issued instruction.
- in_trap  out  1  handler active.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all outputs 0, including epc, cause, vec_addr and the squash counter.
- Trap request: req = dec_valid & (TAGtrap | pov_unflow | GStrap | trapinstr). Flags are ignored when dec_valid=0.
- Cause priority (highest first):
  - TAGtrap: 3'd1.
  - pov_unflow: 3'd2.
  - GStrap: 3'd3.
  - trapinstr: 3'd4.
  - Any req while in_trap=1 overrides to double fault, 3'd7.
- vec_addr = VEC_BASE + {cause, 4'b0000}, 32-bit; carry-out discarded.
- FSM states: IDLE, SQUASH, SAVE, VECTOR.
- IDLE:
  - On req, capture epc<=pc and cause on the same edge, load counter=SQUASH_CYCLES-1, then go to SQUASH.
  - pipe_hold rises the cycle after req; no combinational path from inputs to outputs.
- SQUASH:
  - pipe_hold=1, pipe_squash=1.
  - Counter decrements each cycle; at 0, go to SAVE.
  - pipe_squash is high for exactly SQUASH_CYCLES cycles.
- SAVE:
  - One cycle, pipe_hold=1.
  - Registers vec_addr, sets in_trap<=1, then goes to VECTOR.
- VECTOR:
  - pipe_hold=1, vec_valid=1; vec_addr is stable while vec_valid=1 and vec_ready=0.
  - On vec_valid & vec_ready: vec_valid<=0, pipe_hold<=0, go to IDLE.
  - If vec_ready is already high on entry, the transfer takes one cycle.
- New requests in SQUASH/SAVE/VECTOR are dropped, because the pipe is held and squashed. epc and cause do not change until back in IDLE.
- trap_ret: clears in_trap in any state except SAVE. If trap_ret and req arrive in the same IDLE cycle, req wins: the trap uses cause from in_trap's old value, and in_trap stays 1.
- Skip:
  - In IDLE with dec_valid & skipCONDenable & skip_cond and no req: skip_next<=1 for exactly one cycle.
  - A same-cycle req suppresses skip.
  - skip_next is forced 0 in all non-IDLE states.
- Reset mid-sequence returns to IDLE immediately, with all outputs cleared asynchronously.

Test Plan:
- Reset, then dec_valid=1, TAGtrap=1, pc=32'h0000_4A3C -> next cycle pipe_hold=1, squash 2 cycles, then SAVE. Then vec_valid=1, vec_addr=32'h0000_0110, epc=32'h0000_4A3C, cause=1, in_trap=1.
- TAGtrap, GStrap and trapinstr together, pc=32'h10 -> cause=1. Repeat with GStrap and trapinstr only -> cause=3, vec_addr=32'h0000_0130.
- vec_ready held 0 for 5 cycles in VECTOR -> vec_valid and vec_addr stable for 5 cycles. vec_ready=1 -> vec_valid=0 and pipe_hold=0 next cycle, state IDLE.
- With in_trap=1, pov_unflow request -> cause=7, vec_addr=32'h0000_0170. Then trap_ret in IDLE -> in_trap=0.
- dec_valid=1, skipCONDenable=1, skip_cond=1, no trap -> skip_next=1 for 1 cycle. Same with trapinstr=1 -> skip_next stays 0, cause=4.
- Assert rst_n=0 mid-VECTOR -> vec_valid, pipe_hold and in_trap go 0 asynchronously. After release, a trapinstr request runs a full sequence.
